// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO deserializer.
package sipo_pkg;

  typedef enum logic {
    ST_SHIFT  = 1'b0,
    ST_PARITY = 1'b1
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Bit counter must hold 0..WIDTH-1; sized for WIDTH+1 values to stay safe at powers of two.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Valid/ready holding register for completed words; a load lands one cycle later when empty or draining.
// A load refused because the held word is not consumed is reported on dropped_o and leaves dat_o untouched.
module sipo_out_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          rdy_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o,
  output logic          accepted_o,
  output logic          dropped_o
);

  logic [DW-1:0] dat_q;
  logic          vld_q;

  assign accepted_o = load_i & (~vld_q | rdy_i);
  assign dropped_o  = load_i & vld_q & ~rdy_i;
  assign dat_o      = dat_q;
  assign vld_o      = vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else if (accepted_o) begin
      dat_q <= load_data_i;
      vld_q <= 1'b1;
    end else if (rdy_i) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with sync realign and sticky overrun; word valid the cycle after its last bit.
// Optional even parity bit per frame when SIPO_PARITY_EN is defined (adds the PARITY state and par_err).
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr
`ifdef SIPO_PARITY_EN
  ,
  output logic             par_err
`endif
);

  if (WIDTH < int'(WIDTH_MIN) || WIDTH > int'(WIDTH_MAX)) begin : g_bad_width
    $error("sipo_deser: WIDTH out of range");
  end

  localparam int CW = int'(cnt_width(WIDTH));
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nxt;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             overrun_q, overrun_d;
  logic             load;
  logic [DW-1:0]    load_data;
  logic [DW-1:0]    out_dat;
  logic             out_accepted, out_dropped;
`ifdef SIPO_PARITY_EN
  state_e           state_q, state_d;
`endif

  assign shreg_nxt = {shreg_q[WIDTH-2:0], sdi};

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    load_data = '0;
`ifdef SIPO_PARITY_EN
    state_d   = state_q;
`endif
    if (sync) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
`ifdef SIPO_PARITY_EN
      state_d   = ST_SHIFT;
`endif
    end else if (sdi_en) begin
`ifdef SIPO_PARITY_EN
      if (state_q == ST_PARITY) begin
        // Parity bit is not shifted in; it only qualifies the word already held in shreg.
        load      = 1'b1;
        load_data = {(^shreg_q) ^ sdi, shreg_q};
        state_d   = ST_SHIFT;
      end else begin
        shreg_d = shreg_nxt;
        if (bit_cnt_q == LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_PARITY;
        end else begin
          bit_cnt_d = CW'(bit_cnt_q + 1'b1);
        end
      end
`else
      shreg_d = shreg_nxt;
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
        load      = 1'b1;
        load_data = shreg_nxt;
      end else begin
        bit_cnt_d = CW'(bit_cnt_q + 1'b1);
      end
`endif
    end
    overrun_d = out_dropped | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_q   <= ST_SHIFT;
`endif
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
      state_q   <= state_d;
`endif
    end
  end

  sipo_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .load_data_i (load_data),
    .rdy_i       (dout_ready),
    .dat_o       (out_dat),
    .vld_o       (dout_valid),
    .accepted_o  (out_accepted),
    .dropped_o   (out_dropped)
  );

  always_comb assert (!(out_accepted && out_dropped));

  assign dout    = out_dat[WIDTH-1:0];
  assign overrun = overrun_q;
`ifdef SIPO_PARITY_EN
  assign par_err = out_dat[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus a randomized run against a bit-queue reference model.
module tb_sipo_deser;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sdi = 1'b0, sdi_en = 1'b0, sync = 1'b0, dout_ready = 1'b0, ovr_clr = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid, overrun;
`ifdef SIPO_PARITY_EN
  logic         par_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: bits of the frame in progress, plus the output register contents.
  bit       m_bits[$];
  bit       m_valid, m_ovr, m_perr;
  int       m_dout;

  sipo_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sdi        (sdi),
    .sdi_en     (sdi_en),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
`ifdef SIPO_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bits.delete();
    m_valid = 0; m_ovr = 0; m_perr = 0; m_dout = 0;
  endtask

  task automatic model_step(input bit b, input bit en, input bit s, input bit rdy, input bit clr);
    bit done = 0, drop = 0, pe = 0, consume;
    int word = 0;
    consume = m_valid && rdy;
    if (s) m_bits.delete();
    else if (en) begin
      m_bits.push_back(b);
      if (m_bits.size() == W + PAR) begin
        for (int i = 0; i < W; i++) word = word * 2 + int'(m_bits[i]);
        for (int i = 0; i < W + PAR; i++) pe = pe ^ m_bits[i];
        done = 1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || consume) begin m_valid = 1; m_dout = word; m_perr = pe; end
      else drop = 1;
    end else if (consume) m_valid = 0;
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic cyc(input logic b, input logic en, input logic s, input logic rdy, input logic clr);
    sdi = b; sdi_en = en; sync = s; dout_ready = rdy; ovr_clr = clr;
    @(posedge clk); #1;
    model_step(b, en, s, rdy, clr);
    sdi_en = 1'b0; sync = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_body, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--)
      cyc(w[i], 1'b1, 1'b0, (i == 0 && PAR == 0) ? rdy_last : rdy_body, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(^w, 1'b1, 1'b0, rdy_last, 1'b0);
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b exp 0", dout_valid); end
    send_word(4'hB, 1'b1, 1'b1);
    checks++; if (dout !== 4'hB) begin errors++; $display("FAIL basic_dout got %h exp b", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clr got %b exp 0", dout_valid); end
  endtask

  task automatic test_overrun();
    send_word(4'hB, 1'b0, 1'b0);
    send_word(4'h6, 1'b0, 1'b0);
    checks++; if (dout !== 4'hB) begin errors++; $display("FAIL ovr_dout got %h exp b", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
  endtask

  task automatic test_same_cycle();
    send_word(4'h3, 1'b0, 1'b0);
    checks++; if (dout !== 4'h3) begin errors++; $display("FAIL same_pending got %h exp 3", dout); end
    send_word(4'hC, 1'b0, 1'b1);
    checks++; if (dout !== 4'hC) begin errors++; $display("FAIL same_dout got %h exp c", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL same_valid got %b exp 1", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_overrun got %b exp 0", overrun); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sync();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL sync_valid_mid got %b exp 0", dout_valid); end
    send_word(4'h5, 1'b1, 1'b1);
    checks++; if (dout !== 4'h5) begin errors++; $display("FAIL sync_dout got %h exp 5", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL sync_valid got %b exp 1", dout_valid); end
  endtask

  task automatic test_gaps_reset();
    logic [W-1:0] w = 4'h9;
    for (int i = W - 1; i >= -PAR; i--) begin
      int gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc((i >= 0) ? w[i] : ^w, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (dout !== 4'h9) begin errors++; $display("FAIL gaps_dout got %h exp 9", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b exp 1", dout_valid); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL arst_dout got %h exp 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun got %b exp 0", overrun); end
`ifdef SIPO_PARITY_EN
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL arst_par_err got %b exp 0", par_err); end
`endif
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_word(4'h7, 1'b1, 1'b1);
    checks++; if (dout !== 4'h7) begin errors++; $display("FAIL post_rst_dout got %h exp 7", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b exp 1", dout_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [4:0] good = 5'b10111;
    logic [4:0] bad  = 5'b10110;
    for (int i = 4; i >= 0; i--) cyc(good[i], 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (dout !== 4'hB) begin errors++; $display("FAIL par_good_dout got %h exp b", dout); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good_err got %b exp 0", par_err); end
    for (int i = 4; i >= 0; i--) cyc(bad[i], 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", par_err); end
    for (int i = 4; i >= 0; i--) cyc(good[i], 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_drop_err got %b exp 1", par_err); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL par_drop_ovr got %b exp 1", overrun); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bit busy = ((n / 400) % 2) == 1;
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 39) == 0),
          busy ? 1'($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0));
      checks++; if (dout_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, dout_valid, m_valid); end
      checks++; if (dout !== W'(m_dout)) begin errors++; $display("FAIL rnd_dout n=%0d got %h exp %h", n, dout, W'(m_dout)); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun n=%0d got %b exp %b", n, overrun, m_ovr); end
`ifdef SIPO_PARITY_EN
      checks++; if (par_err !== m_perr) begin errors++; $display("FAIL rnd_par_err n=%0d got %b exp %b", n, par_err, m_perr); end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_same_cycle();
    test_sync();
    test_gaps_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
